// File: rtl/gfx_cmd_sched_if.sv
// Host-command and raster-engine signal bundle for gfx_cmd_sched.
// Handshake: a command transfers on every rising edge where cmd_valid && cmd_ready; start_* are one-cycle pulses answered by eng_busy.
interface gfx_cmd_sched_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic        cmd_fill_value;
    logic [95:0] cmd_geom;
    logic        eng_busy;
    logic [95:0] eng_geom;
    logic        start_blit;
    logic        start_fill;
    logic        fill_value;

    modport slave (
        input  cmd_valid, cmd_op, cmd_fill_value, cmd_geom, eng_busy,
        output cmd_ready, eng_geom, start_blit, start_fill, fill_value
    );

    modport master (
        output cmd_valid, cmd_op, cmd_fill_value, cmd_geom, eng_busy,
        input  cmd_ready, eng_geom, start_blit, start_fill, fill_value
    );
endinterface

// File: rtl/gfx_cmd_sched.sv
// Queues blit/fill commands from the host and issues them one at a time to the raster engine.
// Define GFX_SCHED_TIMEOUT_EN to add a watchdog that abandons commands the engine never completes.
module gfx_cmd_sched #(
    parameter int  DEPTH          = 4,
    parameter int  TIMEOUT_CYCLES = 65535,
    localparam int LW             = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    gfx_cmd_sched_if.slave bus,
    input  logic          clear_err,
    output logic [LW-1:0] level,
    output logic          overflow,
    output logic          timeout,
    output logic [1:0]    state_dbg
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = 98;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_ACK  = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [CW-1:0] mem [DEPTH];
    logic [CW-1:0] head;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          full;
    logic          empty;
    logic          ready;
    logic          push;
    logic          drop;
    logic          pop;
    logic          op_q;
    logic          fv_q;
    logic [95:0]   geom_q;
    logic          overflow_q;
    logic          wd_expired;

    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == '0);
    assign ready = rst_n && !full;
    assign push  = bus.cmd_valid && ready;
    assign drop  = bus.cmd_valid && full;
    // Pop only uses the registered level, so a command pushed into an empty FIFO waits one edge.
    assign pop   = (state_q == S_IDLE) && !empty && !bus.eng_busy;
    assign head  = mem[rd_ptr_q];

    // ---------------------------------------------------------------- FIFO
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {bus.cmd_op, bus.cmd_fill_value, bus.cmd_geom};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // ---------------------------------------------------------------- issue FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (pop) state_d = S_ISSUE;
            S_ISSUE:     state_d = S_WAIT_ACK;
            S_WAIT_ACK:  if (bus.eng_busy) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (!bus.eng_busy) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        if (wd_expired) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Geometry, fill value and opcode change only on a pop and hold for the whole operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= 1'b0;
            fv_q   <= 1'b0;
            geom_q <= '0;
        end else if (pop) begin
            op_q   <= head[97];
            fv_q   <= head[96];
            geom_q <= head[95:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (clear_err) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    // ---------------------------------------------------------------- watchdog
`ifdef GFX_SCHED_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_cnt_q;
    logic        waiting;
    logic        timeout_q;

    assign waiting    = (state_q == S_WAIT_ACK) || (state_q == S_WAIT_DONE);
    assign wd_expired = waiting && (wd_cnt_q == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
        end else if (!waiting || wd_expired) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else if (clear_err) begin
            timeout_q <= 1'b0;
        end else if (wd_expired) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    assign wd_expired = 1'b0;
    assign timeout    = 1'b0;
`endif

    // ---------------------------------------------------------------- outputs
    assign bus.cmd_ready  = ready;
    assign bus.start_blit = (state_q == S_ISSUE) && !op_q;
    assign bus.start_fill = (state_q == S_ISSUE) && op_q;
    assign bus.eng_geom   = geom_q;
    assign bus.fill_value = fv_q;
    assign level          = level_q;
    assign overflow       = overflow_q;
    assign state_dbg      = state_q;

`ifndef SYNTHESIS
    a_params: assert property (@(posedge clk)
        (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0) &&
        (TIMEOUT_CYCLES >= 1) && (TIMEOUT_CYCLES <= 65535));
    a_start_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.start_blit && bus.start_fill));
    a_start_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.start_blit || bus.start_fill) |=> !(bus.start_blit || bus.start_fill));
    a_geom_hold: assert property (@(posedge clk) disable iff (!rst_n)
        !pop |=> $stable(geom_q));
    a_level_max: assert property (@(posedge clk) disable iff (!rst_n)
        level_q <= FULL_LEVEL);
`endif

endmodule

// File: tb/tb_gfx_cmd_sched.sv
// Bench for gfx_cmd_sched: directed steps, then random traffic checked against an in-order command queue.
// Define GFX_SCHED_TIMEOUT_EN for both DUT and bench to include the watchdog step.
module tb_gfx_cmd_sched;

    localparam int DEPTH = 4;
    localparam int LW    = 3;
    localparam int CW    = 98;
`ifdef GFX_SCHED_TIMEOUT_EN
    localparam int TO_CYC = 50;
`else
    localparam int TO_CYC = 65535;
`endif

    // ---------------------------------------------------------------- clock / reset
    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic clear_err = 1'b0;
    always #5 clk = ~clk;

    logic [LW-1:0] level;
    logic          overflow;
    logic          timeout;
    logic [1:0]    state_dbg;

    gfx_cmd_sched_if bus();

    gfx_cmd_sched #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clear_err (clear_err),
        .level     (level),
        .overflow  (overflow),
        .timeout   (timeout),
        .state_dbg (state_dbg)
    );

    // Engine: either an automatic responder or busy driven directly by the test steps.
    logic auto_eng  = 1'b1;
    logic auto_busy = 1'b0;
    logic man_busy  = 1'b0;
    int   busy_len  = 10;
    bit   rand_busy = 1'b0;
    assign bus.eng_busy = auto_eng ? auto_busy : man_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int starts = 0;
    int start_cyc[$];
    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] exp_e;
    bit prev_start = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [95:0] mk_geom(input int x1, input int y1, input int x2,
                                           input int y2, input int w, input int h);
        return {16'(h), 16'(w), 16'(y2), 16'(x2), 16'(y1), 16'(x1)};
    endfunction

    // ---------------------------------------------------------------- driver tasks
    task automatic push(input logic op, input logic fv, input logic [95:0] g, input bit accept);
        bus.cmd_valid      = 1'b1;
        bus.cmd_op         = op;
        bus.cmd_fill_value = fv;
        bus.cmd_geom       = g;
        if (accept) exp_q.push_back({op, fv, g});
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_starts(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (starts < target && k < budget) begin
            step();
            k++;
        end
        check(tag, starts >= target, 1);
    endtask

    // ---------------------------------------------------------------- engine responder
    initial begin
        forever begin
            @(negedge clk);
            if (auto_eng && rst_n && (bus.start_blit || bus.start_fill)) begin
                int n;
                n = rand_busy ? int'($urandom_range(2, 9)) : busy_len;
                @(negedge clk);
                auto_busy = 1'b1;
                repeat (n) @(negedge clk);
                auto_busy = 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_start = 1'b0;
        end else begin
            if (bus.start_blit || bus.start_fill) begin
                check("start_excl", bus.start_blit & bus.start_fill, 0);
                check("start_one_cycle", prev_start, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_start", 1, 0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("start_op", bus.start_fill, exp_e[97]);
                    check("eng_geom", bus.eng_geom, exp_e[95:0]);
                    if (exp_e[97]) check("fill_value", bus.fill_value, exp_e[96]);
                end
                starts++;
                start_cyc.push_back(cyc);
            end
            prev_start = bus.start_blit || bus.start_fill;
        end
    end

    initial begin
        #2000000;
        $display("FAIL sim_timeout: observed=running expected=finished");
        $fatal(1);
    end

    // ---------------------------------------------------------------- directed steps
    initial begin
        int base;
        int sbase;
        int k;
        bus.cmd_valid      = 1'b0;
        bus.cmd_op         = 1'b0;
        bus.cmd_fill_value = 1'b0;
        bus.cmd_geom       = '0;

        // Reset values
        repeat (3) step();
        check("rst_start_blit", bus.start_blit, 0);
        check("rst_start_fill", bus.start_fill, 0);
        check("rst_eng_geom", bus.eng_geom, 0);
        check("rst_fill_value", bus.fill_value, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_timeout", timeout, 0);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        rst_n = 1'b1;
        step();
        check("ready_after_rst", bus.cmd_ready, 1);

        // Single fill, minimum latency
        busy_len = 10;
        base = starts;
        push(1'b1, 1'b1, mk_geom(20, 40, 150, 160, 131, 121), 1'b1);
        check("lat_level_after_push", level, 1);
        check("lat_no_start_yet", bus.start_fill, 0);
        step();
        check("lat_start_fill", bus.start_fill, 1);
        check("lat_start_blit", bus.start_blit, 0);
        check("lat_eng_geom", bus.eng_geom, mk_geom(20, 40, 150, 160, 131, 121));
        check("lat_fill_value", bus.fill_value, 1);
        check("lat_level_after_pop", level, 0);
        step();
        check("lat_pulse_end", bus.start_fill, 0);
        repeat (15) step();
        check("fill_geom_held", bus.eng_geom, mk_geom(20, 40, 150, 160, 131, 121));
        check("fill_starts", starts - base, 1);

        // Fill the FIFO while the engine is busy, then overflow
        busy_len = 12;
        base  = starts;
        sbase = start_cyc.size();
        push(1'b0, 1'b0, mk_geom(1, 2, 3, 4, 3, 3), 1'b1);
        push(1'b1, 1'b0, mk_geom(10, 11, 12, 13, 3, 3), 1'b1);
        push(1'b0, 1'b1, mk_geom(20, 21, 22, 23, 3, 3), 1'b1);
        push(1'b1, 1'b1, mk_geom(30, 31, 32, 33, 3, 3), 1'b1);
        push(1'b0, 1'b0, mk_geom(40, 41, 42, 43, 3, 3), 1'b1);
        check("full_level", level, 4);
        check("full_not_ready", bus.cmd_ready, 0);
        check("full_no_overflow_yet", overflow, 0);
        push(1'b1, 1'b1, mk_geom(99, 99, 99, 99, 9, 9), 1'b0);
        check("overflow_set", overflow, 1);
        check("overflow_level_kept", level, 4);
        wait_starts(base + 5, 200, "full_all_issued");
        for (int i = 1; i < 5; i++) begin
            check("throughput", start_cyc[sbase + i] - start_cyc[sbase + i - 1], busy_len + 3);
        end
        repeat (20) step();
        check("full_drained_level", level, 0);
        check("full_drained_queue", exp_q.size(), 0);

        // Push and pop on the same edge at level 2, then clear_err
        auto_eng = 1'b0;
        man_busy = 1'b0;
        base = starts;
        push(1'b0, 1'b0, mk_geom(5, 6, 7, 8, 1, 1), 1'b1);
        push(1'b1, 1'b1, mk_geom(15, 16, 17, 18, 2, 2), 1'b1);
        man_busy = 1'b1;
        push(1'b0, 1'b0, mk_geom(25, 26, 27, 28, 3, 3), 1'b1);
        step();
        step();
        check("pp_level_before", level, 2);
        man_busy = 1'b0;
        step();
        push(1'b1, 1'b0, mk_geom(35, 36, 37, 38, 4, 4), 1'b1);
        check("pp_level_same", level, 2);
        check("pp_start_seen", bus.start_blit | bus.start_fill, 1);
        check("pp_overflow_still", overflow, 1);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check("clear_err_overflow", overflow, 0);
        man_busy = 1'b1;
        repeat (3) step();
        busy_len = 5;
        man_busy = 1'b0;
        auto_eng = 1'b1;
        wait_starts(base + 4, 100, "pp_all_issued");
        repeat (12) step();

        // Reset while waiting for the engine with three commands queued
        busy_len = 30;
        base = starts;
        push(1'b0, 1'b0, mk_geom(50, 51, 52, 53, 5, 5), 1'b1);
        push(1'b1, 1'b1, mk_geom(60, 61, 62, 63, 6, 6), 1'b1);
        push(1'b0, 1'b0, mk_geom(70, 71, 72, 73, 7, 7), 1'b1);
        push(1'b1, 1'b0, mk_geom(80, 81, 82, 83, 8, 8), 1'b1);
        repeat (3) step();
        check("mid_level", level, 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_start_blit", bus.start_blit, 0);
        check("mid_rst_start_fill", bus.start_fill, 0);
        check("mid_rst_eng_geom", bus.eng_geom, 0);
        check("mid_rst_fill_value", bus.fill_value, 0);
        check("mid_rst_level", level, 0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        repeat (8) step();
        check("post_rst_no_start", starts - base, 1);
        check("post_rst_level", level, 0);
        push(1'b1, 1'b1, mk_geom(90, 91, 92, 93, 9, 9), 1'b1);
        repeat (5) step();
        check("post_rst_waits_busy", starts - base, 1);
        check("post_rst_queued", level, 1);
        wait_starts(base + 2, 80, "post_rst_issued");
        repeat (40) step();

        // Zero-size blit still needs the busy handshake
        auto_eng = 1'b0;
        man_busy = 1'b0;
        base = starts;
        push(1'b0, 1'b1, mk_geom(7, 7, 7, 7, 0, 0), 1'b1);
        step();
        check("zero_start_blit", bus.start_blit, 1);
        push(1'b1, 1'b0, mk_geom(3, 3, 9, 9, 7, 7), 1'b1);
        repeat (10) step();
        check("zero_waits_ack", starts - base, 1);
        check("zero_next_queued", level, 1);
        man_busy = 1'b1;
        repeat (3) step();
        busy_len = 4;
        man_busy = 1'b0;
        auto_eng = 1'b1;
        wait_starts(base + 2, 40, "zero_next_issued");
        repeat (10) step();

`ifdef GFX_SCHED_TIMEOUT_EN
        // Watchdog with an engine that never answers
        auto_eng = 1'b0;
        man_busy = 1'b0;
        base = starts;
        push(1'b0, 1'b0, mk_geom(11, 12, 13, 14, 2, 2), 1'b1);
        push(1'b1, 1'b1, mk_geom(21, 22, 23, 24, 2, 2), 1'b1);
        repeat (45) step();
        check("wd_not_yet", timeout, 0);
        k = 0;
        while (!timeout && k < 15) begin
            step();
            k++;
        end
        check("wd_timeout_set", timeout, 1);
        wait_starts(base + 2, 20, "wd_next_issued");
        repeat (60) step();
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check("wd_timeout_cleared", timeout, 0);
        auto_eng = 1'b1;
`endif

        // Random traffic against the in-order reference queue
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        rand_busy = 1'b1;
        base = starts;
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            repeat (gap) step();
            k = 0;
            while (!bus.cmd_ready && k < 200) begin
                step();
                k++;
            end
            if (k >= 200) check("rand_ready_wait", bus.cmd_ready, 1);
            push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 {$urandom(), $urandom(), $urandom()}, 1'b1);
        end
        wait_starts(base + 40, 800, "rand_all_issued");
        repeat (15) step();
        check("rand_queue_empty", exp_q.size(), 0);
        check("rand_level", level, 0);
        check("rand_overflow", overflow, 0);
        check("rand_timeout", timeout, 0);
        check("rand_ready", bus.cmd_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
